// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch stage between the PC register and decode.
//   Reads instruction memory at the current PC over a req/ack handshake.
//   Latches the instruction together with its PC and PC+4, then offers it
//   to decode over a valid/ready handshake.
//   pc_advance tells PS-select logic to step the PC; it is high only on the
//   edge where the instruction is latched.
// Ports:
//   clock, reset      rising-edge clock, async active-high reset
//   pc, flush         current PC; redirect (branch target loads this edge)
//   imem_req/addr     word read request, held until imem_ack
//   imem_ack/rdata    read data return
//   if_valid/ready    handshake to decode
//   if_instr/pc/pc4   latched instruction, its address, address+4
//   pc_advance        PC <- PC+4 at this edge (combinational)
//   fetch_count       instructions handed to decode (wraps)
module instruction_fetch #(
  parameter int AW  = 64,
  parameter int IW  = 32,
  parameter int FCW = 32
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [AW-1:0]  pc,
  input  logic           flush,
  output logic           imem_req,
  output logic [AW-1:0]  imem_addr,
  input  logic           imem_ack,
  input  logic [IW-1:0]  imem_rdata,
  output logic           if_valid,
  input  logic           if_ready,
  output logic [IW-1:0]  if_instr,
  output logic [AW-1:0]  if_pc,
  output logic [AW-1:0]  if_pc4,
  output logic           pc_advance,
  output logic [FCW-1:0] fetch_count
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  req_addr_q, req_addr_d;
  logic [IW-1:0]  if_instr_q, if_instr_d;
  logic [AW-1:0]  if_pc_q, if_pc_d;
  logic [AW-1:0]  if_pc4_q, if_pc4_d;
  logic [FCW-1:0] fetch_count_q, fetch_count_d;
  logic [AW-1:0]  pc_aligned;

  // Misaligned PCs are not flagged; the low two bits are simply dropped.
  assign pc_aligned = pc & ~AW'(3);

  always_comb begin
    state_d       = state_q;
    req_addr_d    = req_addr_q;
    if_instr_d    = if_instr_q;
    if_pc_d       = if_pc_q;
    if_pc4_d      = if_pc4_q;
    fetch_count_d = fetch_count_q;
    case (state_q)
      IDLE: begin
        state_d    = REQ;
        req_addr_d = pc_aligned;
      end
      REQ: begin
        if (imem_ack && !flush) begin
          if_instr_d = imem_rdata;
          if_pc_d    = req_addr_q;
          if_pc4_d   = req_addr_q + AW'(4);
          state_d    = HOLD;
        end else if (imem_ack && flush) begin
          // Data belongs to the squashed path; re-issue at the new PC.
          state_d    = REQ;
          req_addr_d = pc_aligned;
        end else if (flush) begin
          // Request already outstanding: wait out its ack before redirecting.
          state_d = DROP;
        end
      end
      DROP: begin
        if (imem_ack) begin
          state_d    = REQ;
          req_addr_d = pc_aligned;
        end
      end
      HOLD: begin
        if (flush) begin
          state_d    = REQ;
          req_addr_d = pc_aligned;
        end else if (if_ready) begin
          fetch_count_d = fetch_count_q + FCW'(1);
          state_d       = REQ;
          req_addr_d    = pc_aligned;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      req_addr_q    <= '0;
      if_instr_q    <= '0;
      if_pc_q       <= '0;
      if_pc4_q      <= '0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      req_addr_q    <= req_addr_d;
      if_instr_q    <= if_instr_d;
      if_pc_q       <= if_pc_d;
      if_pc4_q      <= if_pc4_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Request decodes from the state register only, so reset drops it at once.
  assign imem_req    = (state_q == REQ) || (state_q == DROP);
  assign imem_addr   = req_addr_q;
  assign if_valid    = (state_q == HOLD) && !flush;
  assign pc_advance  = (state_q == REQ) && imem_ack && !flush;
  assign if_instr    = if_instr_q;
  assign if_pc       = if_pc_q;
  assign if_pc4      = if_pc4_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: stimulus pushes expected transfers,
// a negedge monitor pops them whenever decode accepts an instruction.
module tb_instruction_fetch;
  localparam int AW  = 64;
  localparam int IW  = 32;
  localparam int FCW = 4;

  logic           clock, reset, flush, imem_req, imem_ack, if_valid, if_ready, pc_advance;
  logic [AW-1:0]  pc, imem_addr, if_pc, if_pc4;
  logic [IW-1:0]  imem_rdata, if_instr;
  logic [FCW-1:0] fetch_count;

  instruction_fetch #(.AW(AW), .IW(IW), .FCW(FCW)) dut (
    .clock(clock), .reset(reset), .pc(pc), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc), .if_pc4(if_pc4),
    .pc_advance(pc_advance), .fetch_count(fetch_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [IW-1:0] instr;
    logic [AW-1:0] pc;
    logic [AW-1:0] pc4;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int exp_count = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // DUT is in REQ at addr; memory acks after `waits` idle cycles.
  task automatic do_req(input logic [AW-1:0] addr, input logic [IW-1:0] rdata, input int waits);
    exp_t e;
    for (int i = 0; i < waits; i++) begin
      imem_ack = 1'b0;
      #1;
      chk("wait_req", imem_req, 1);
      chk("wait_addr", imem_addr, addr);
      chk("wait_pc_advance", pc_advance, 0);
      tick();
    end
    imem_ack   = 1'b1;
    imem_rdata = rdata;
    #1;
    chk("ack_req", imem_req, 1);
    chk("ack_addr", imem_addr, addr);
    chk("ack_pc_advance", pc_advance, 1);
    e.instr = rdata;
    e.pc    = addr;
    e.pc4   = addr + 64'd4;
    sb.push_back(e);
    tick();
    imem_ack = 1'b0;
  endtask

  // DUT is in HOLD; decode stalls, then accepts. next_pc is what the PC holds.
  task automatic do_hold(input int stalls, input logic [AW-1:0] next_pc);
    pc = next_pc;
    for (int i = 0; i < stalls; i++) begin
      if_ready = 1'b0;
      #1;
      chk("stall_valid", if_valid, 1);
      chk("stall_req", imem_req, 0);
      chk("stall_pc_advance", pc_advance, 0);
      chk("stall_instr", if_instr, sb[0].instr);
      chk("stall_pc", if_pc, sb[0].pc);
      chk("stall_count", fetch_count, exp_count);
      tick();
    end
    if_ready = 1'b1;
    #1;
    chk("hold_valid", if_valid, 1);
    tick();
    if_ready  = 1'b0;
    exp_count = (exp_count + 1) % 16;
    chk("count", fetch_count, exp_count);
  endtask

  // Monitor: every accepted transfer must match the oldest expected entry.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && if_valid && if_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid actual pc=%0h expected none", if_pc);
      end else begin
        e = sb.pop_front();
        chk("mon_instr", if_instr, e.instr);
        chk("mon_pc", if_pc, e.pc);
        chk("mon_pc4", if_pc4, e.pc4);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [AW-1:0] a;
    reset = 1'b1; pc = '0; flush = 1'b0; imem_ack = 1'b0;
    imem_rdata = '0; if_ready = 1'b0;
    #13;
    chk("rst_req", imem_req, 0);
    chk("rst_valid", if_valid, 0);
    chk("rst_pc_advance", pc_advance, 0);
    chk("rst_count", fetch_count, 0);
    chk("rst_instr", if_instr, 0);
    chk("rst_pc", if_pc, 0);
    chk("rst_pc4", if_pc4, 0);
    tick();
    reset = 1'b0;
    #1;
    chk("idle_req", imem_req, 0);
    tick();

    // Zero-wait fetch at 0x0.
    do_req(64'h0, 32'h8B020020, 0);
    do_hold(0, 64'h100);

    // Three wait cycles at 0x100, then five cycles of backpressure.
    do_req(64'h100, 32'hD2800020, 3);
    do_hold(5, 64'h103);

    // Misaligned PC 0x103 fetches from 0x100.
    do_req(64'h100, 32'hAA000001, 0);
    do_hold(0, 64'h200);

    // Flush in REQ with no ack: DROP, ack two cycles later is discarded.
    flush = 1'b1;
    #1;
    chk("flush_req_pc_advance", pc_advance, 0);
    chk("flush_req_valid", if_valid, 0);
    tick();
    flush = 1'b0;
    pc = 64'h400;
    #1;
    chk("drop_req", imem_req, 1);
    chk("drop_addr", imem_addr, 64'h200);
    chk("drop_pc_advance", pc_advance, 0);
    tick();
    imem_ack = 1'b1;
    imem_rdata = 32'hDEADBEEF;
    #1;
    chk("drop_ack_pc_advance", pc_advance, 0);
    chk("drop_ack_valid", if_valid, 0);
    tick();
    imem_ack = 1'b0;
    #1;
    chk("redirect_addr", imem_addr, 64'h400);
    do_req(64'h400, 32'h91000421, 0);

    // Flush with if_ready in HOLD: no transfer, count unchanged.
    pc = 64'hFFFF_FFFF_FFFF_FFFC;
    flush = 1'b1;
    if_ready = 1'b1;
    #1;
    chk("flush_hold_valid", if_valid, 0);
    chk("flush_hold_pc_advance", pc_advance, 0);
    void'(sb.pop_front());
    tick();
    flush = 1'b0;
    if_ready = 1'b0;
    #1;
    chk("flush_hold_count", fetch_count, exp_count);
    chk("flush_hold_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);

    // Top-of-address-space fetch: PC+4 wraps to zero.
    do_req(64'hFFFF_FFFF_FFFF_FFFC, 32'hD65F03C0, 0);
    chk("pc4_wrap", if_pc4, 64'h0);
    do_hold(0, 64'h0);

    // Flush coinciding with ack in REQ: data dropped, re-request at 0x40.
    pc = 64'h40;
    flush = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'h12345678;
    #1;
    chk("flush_ack_pc_advance", pc_advance, 0);
    tick();
    flush = 1'b0;
    imem_ack = 1'b0;
    #1;
    chk("flush_ack_req", imem_req, 1);
    chk("flush_ack_addr", imem_addr, 64'h40);

    // Run the counter up to all-ones, then one more transfer wraps it.
    a = 64'h40;
    while (exp_count != 15) begin
      do_req(a, a[31:0], 0);
      a = a + 64'd4;
      do_hold(0, a);
    end
    do_req(a, 32'hCAFEF00D, 0);
    do_hold(0, a + 64'd4);
    chk("count_wrap", fetch_count, 0);

    // Reset in the middle of a request drops imem_req asynchronously.
    #1;
    chk("pre_reset_req", imem_req, 1);
    reset = 1'b1;
    #1;
    chk("async_reset_req", imem_req, 0);
    chk("async_reset_count", fetch_count, 0);
    tick();
    reset = 1'b0;

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage directly downstream of the program counter. Takes the current PC, issues a word read to instruction memory over a req/ack handshake, and latches the returned 32-bit instruction with its PC and PC+4. Presents the result to decode over a valid/ready handshake. Drives `pc_advance`, which the PS-select logic maps to PS=01 when high and PS=00 when low, so the PC holds during stalls.

## Interface
- `AW`, default 64: address and PC width.
- `IW`, default 32: instruction width.
- `FCW`, default 32: width of the fetch counter.

Ports:
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `pc`  in  AW  current PC register value.
- `flush`  in  1  redirect: PC loads a branch target at this edge; discard any held or in-flight fetch.
- `imem_req`  out  1  read request to instruction memory.
- `imem_addr`  out  AW  word-aligned read address.
- `imem_ack`  in  1  read data valid this cycle.
- `imem_rdata`  in  IW  instruction word.
- `if_valid`  out  1  instruction available to decode.
- `if_ready`  in  1  decode accepts this cycle.
- `if_instr`  out  IW  latched instruction.
- `if_pc`  out  AW  address of `if_instr`.
- `if_pc4`  out  AW  `if_pc` + 4.
- `pc_advance`  out  1  combinational; high means PC ← PC+4 at this edge.
- `fetch_count`  out  FCW  number of instructions handed to decode.

## Operation
- States: IDLE, REQ, HOLD, DROP.
- Reset (asynchronous):
  - State goes to IDLE.
  - `req_addr`, `if_instr`, `if_pc`, `if_pc4` and `fetch_count` go to 0.
  - All 1-bit outputs go to 0.
- IDLE:
  - No request; `flush` is ignored.
  - Moves to REQ on the next edge.
  - Captures `req_addr` = {`pc`[AW-1:2], 2'b00}.
- REQ:
  - `imem_req` = 1 and `imem_addr` = `req_addr`.
  - Both stay stable until `imem_ack`.
  - `imem_ack` & !`flush`:
    - Latch `if_instr` = `imem_rdata`, `if_pc` = `req_addr`, `if_pc4` = `req_addr` + 4 (mod 2^AW).
    - `pc_advance` = 1 this cycle.
    - Move to HOLD.
  - `imem_ack` & `flush`: discard the data, `pc_advance` = 0, move to REQ again and capture `req_addr` from `pc`.
  - !`imem_ack` & `flush`: move to DROP.
  - Neither: stay in REQ.
- DROP:
  - `imem_req` = 1 and the address is unchanged; an outstanding request is never withdrawn.
  - On `imem_ack`: discard the data, move to REQ and capture `req_addr` from `pc`. By then `pc` is the redirect target.
  - A further `flush` while in DROP has no extra effect.
- HOLD:
  - `if_valid` = !`flush`.
  - `if_ready` & !`flush`: the transfer completes; `fetch_count` += 1 (wraps at 2^FCW); move to REQ and capture `req_addr` from `pc`, which is now PC+4.
  - `flush`: there is no transfer, regardless of `if_ready`; move to REQ and capture `req_addr` from `pc`.
  - Otherwise: stay in HOLD with outputs stable.
- `pc_advance` is high only in the REQ & `imem_ack` & !`flush` cycle. It is never high in IDLE, HOLD or DROP.
- `pc`[1:0] ≠ 0 is not flagged; the low bits are forced to zero on `imem_addr`, and `if_pc` carries the aligned address.

## Timing
- Zero-wait memory (ack in the first REQ cycle): one instruction every 2 cycles (REQ, then HOLD).
- Latency: the `imem_ack` edge sets `if_valid` in the next cycle.
- `if_instr`, `if_pc`, `if_pc4` and `req_addr` are registers.
- `if_valid` and `pc_advance` have a combinational path from `flush` and `imem_ack`; no other outputs depend combinationally on inputs.
- The `pc_advance` pulse and the `if_*` latch happen on the same edge, so `pc` = old PC+4 on the next cycle.
- A `flush` redirect costs at least 1 cycle. In DROP it costs the remaining memory latency, plus 1 cycle.
- Reset asserted mid-request: `imem_req` drops immediately and asynchronously. The memory must tolerate an abandoned request on reset.

## Test plan
- Reset release, `pc`=0x0, ack in the first REQ cycle, `if_ready`=1, `imem_rdata`=0x8B020020:
  - `imem_addr`=0x0 in cycle 2.
  - `if_valid` with `if_instr`=0x8B020020, `if_pc`=0x0, `if_pc4`=0x4.
  - `pc_advance` pulses once.
  - `fetch_count`=1.
- Memory waits 3 cycles before ack, `pc`=0x100:
  - `imem_req` is held for 4 cycles at 0x100.
  - `pc_advance` = 0 until the ack cycle.
- Backpressure: `if_ready`=0 for 5 cycles in HOLD:
  - `if_valid`, `if_instr` and `if_pc` are stable.
  - No new `imem_req`; `pc_advance`=0.
  - `fetch_count` unchanged.
- `flush` in REQ with no ack, target 0x400, ack two cycles later:
  - Those data are dropped with no `if_valid`.
  - The next `imem_addr`=0x400.
- `flush` together with `if_ready` in HOLD:
  - `if_valid`=0 that cycle.
  - `fetch_count` unchanged.
  - The next request goes to the `pc` target.
- `pc`=0xFFFF_FFFF_FFFF_FFFC fetched: `if_pc4`=0x0.
- `pc`=0x103: `imem_addr`=0x100.
- `fetch_count` preset by 2^FCW−1 transfers: the next transfer wraps it to 0.
